// File: rtl/csr_to_ram_banked_rmw_bridge.sv
// Bridges single-outstanding CSR accesses onto NUM_BANKS synchronous single-port RAM banks.
// Define CSR_TO_RAM_BRIDGE_RMW_EN to turn writes with partial bytes into read-modify-write.
module csr_to_ram_banked_rmw_bridge #(
  parameter int unsigned WORD_BIT_WIDTH      = 32,
  parameter int unsigned BYTE_ADDR_BIT_WIDTH = 10,
  parameter int unsigned NUM_BANKS           = 2,
  parameter int unsigned RAM_RD_LATENCY      = 1,
  parameter int unsigned WORD_ADDR_BIT_WIDTH =
    BYTE_ADDR_BIT_WIDTH - $clog2(WORD_BIT_WIDTH / 8) - $clog2(NUM_BANKS)
) (
  input  logic                                i_clk,
  input  logic                                i_sync_rst,
  input  logic                                i_acc_req,
  input  logic                                i_acc_req_is_wr,
  input  logic [BYTE_ADDR_BIT_WIDTH-1:0]      i_byte_addr,
  input  logic [WORD_BIT_WIDTH-1:0]           i_wr_data,
  input  logic [WORD_BIT_WIDTH-1:0]           i_wr_bit_en,
  output logic                                o_rd_ack,
  output logic [WORD_BIT_WIDTH-1:0]           o_rd_data,
  output logic                                o_wr_ack,
  output logic                                o_busy,
  output logic [NUM_BANKS-1:0]                o_ram_re,
  output logic [NUM_BANKS-1:0]                o_ram_we,
  output logic [WORD_ADDR_BIT_WIDTH-1:0]      o_ram_word_addr,
  output logic [WORD_BIT_WIDTH/8-1:0]         o_ram_wr_byte_en,
  output logic [WORD_BIT_WIDTH-1:0]           o_ram_wr_data,
  input  logic [NUM_BANKS*WORD_BIT_WIDTH-1:0] i_ram_rd_data
);

  localparam int unsigned NumBytes = WORD_BIT_WIDTH / 8;
  localparam int unsigned ByteOffW = $clog2(NumBytes);
  localparam int unsigned BankW    = $clog2(NUM_BANKS);
  localparam int unsigned BankIdxW = (BankW > 0) ? BankW : 1;
  localparam int unsigned WordW    = BYTE_ADDR_BIT_WIDTH - ByteOffW;
  localparam int unsigned CntW     = 2;
  localparam logic [CntW-1:0] LastCnt = CntW'(RAM_RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StRmwRdWait, StRmwWr} state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [BankIdxW-1:0]            bank_q;
  logic [WORD_ADDR_BIT_WIDTH-1:0] addr_q;
  logic                           wr_ack_q, wr_ack_d;

  logic [WordW-1:0]          req_word;
  logic [BankIdxW-1:0]       req_bank;
  logic [NUM_BANKS-1:0]      req_sel;
  logic [NumBytes-1:0]       full_be;
  logic                      accept;
  logic                      rmw_req;
  logic                      last_wait;
  logic [WORD_BIT_WIDTH-1:0] rd_slice;
  logic                      unused_addr;

  assign req_word    = i_byte_addr[BYTE_ADDR_BIT_WIDTH-1:ByteOffW];
  assign unused_addr = ^{i_byte_addr, 1'b0};

  if (NUM_BANKS > 1) begin : g_bank
    assign req_bank = req_word[WordW-1 -: BankW];
  end else begin : g_no_bank
    assign req_bank = '0;
  end

  assign req_sel   = NUM_BANKS'(1) << req_bank;
  assign accept    = i_acc_req & (state_q == StIdle) & ~i_sync_rst;
  assign last_wait = (cnt_q == LastCnt);
  assign rd_slice  = i_ram_rd_data[bank_q * WORD_BIT_WIDTH +: WORD_BIT_WIDTH];

  always_comb begin
    full_be = '0;
    for (int k = 0; k < NumBytes; k++) begin
      full_be[k] = &i_wr_bit_en[8*k +: 8];
    end
  end

`ifdef CSR_TO_RAM_BRIDGE_RMW_EN
  logic [WORD_BIT_WIDTH-1:0] wr_data_q, bit_en_q, merged_q;
  logic                      has_partial;

  always_comb begin
    has_partial = 1'b0;
    for (int k = 0; k < NumBytes; k++) begin
      if (!(&i_wr_bit_en[8*k +: 8]) && (|i_wr_bit_en[8*k +: 8])) has_partial = 1'b1;
    end
  end

  assign rmw_req = i_acc_req_is_wr & has_partial;

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      wr_data_q <= '0;
      bit_en_q  <= '0;
      merged_q  <= '0;
    end else begin
      if (accept) begin
        wr_data_q <= i_wr_data;
        bit_en_q  <= i_wr_bit_en;
      end
      if (state_q == StRmwRdWait && last_wait) begin
        merged_q <= (rd_slice & ~bit_en_q) | (wr_data_q & bit_en_q);
      end
    end
  end
`else
  assign rmw_req = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bank_q   <= '0;
      addr_q   <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ack_q <= wr_ack_d;
      if (accept) begin
        bank_q <= req_bank;
        addr_q <= req_word[WORD_ADDR_BIT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ack_d = (state_q == StRmwWr);
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = '0;
          if (!i_acc_req_is_wr) state_d = StRdWait;
          else if (rmw_req)     state_d = StRmwRdWait;
          else                  wr_ack_d = 1'b1;
        end
      end
      StRdWait: begin
        if (last_wait) state_d = StIdle;
        else           cnt_d   = cnt_q + CntW'(1);
      end
      StRmwRdWait: begin
        if (last_wait) state_d = StRmwWr;
        else           cnt_d   = cnt_q + CntW'(1);
      end
      StRmwWr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Every output is forced low while reset is asserted, including the cycle-0 enables.
  always_comb begin
    o_rd_ack         = 1'b0;
    o_rd_data        = '0;
    o_ram_re         = '0;
    o_ram_we         = '0;
    o_ram_word_addr  = '0;
    o_ram_wr_byte_en = '0;
    o_ram_wr_data    = '0;
    o_wr_ack         = wr_ack_q & ~i_sync_rst;
    o_busy           = ~i_sync_rst & ((state_q != StIdle) |
                                      (accept & (~i_acc_req_is_wr | rmw_req)));
    if (!i_sync_rst) begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            o_ram_word_addr = req_word[WORD_ADDR_BIT_WIDTH-1:0];
            if (!i_acc_req_is_wr || rmw_req) begin
              o_ram_re = req_sel;
            end else begin
              o_ram_we         = (|full_be) ? req_sel : '0;
              o_ram_wr_byte_en = full_be;
              o_ram_wr_data    = i_wr_data;
            end
          end
        end
        StRdWait: begin
          o_ram_word_addr = addr_q;
          if (last_wait) begin
            o_rd_ack  = 1'b1;
            o_rd_data = rd_slice;
          end
        end
        StRmwRdWait: o_ram_word_addr = addr_q;
        StRmwWr: begin
          o_ram_word_addr = addr_q;
`ifdef CSR_TO_RAM_BRIDGE_RMW_EN
          o_ram_we         = NUM_BANKS'(1) << bank_q;
          o_ram_wr_byte_en = '1;
          o_ram_wr_data    = merged_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
